// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared definitions for the multi-cycle MIPS control FSM. It holds
//          the state encodings, the opcode constants, the mux select codes,
//          the packed control word and the opcode-legality helper.
// Config : MULTICYCLE_BNE_EN adds the BNEEX state and makes OP_BNE legal.
// Rev    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

  // These are the fixed 4-bit state encodings. Codes 13..15 are never entered.
  // Code 12 is used only when the bne extension is built.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MULTICYCLE_BNE_EN
    S_BNEEX   = 4'd12,
`endif
    S_JEX     = 4'd11
  } state_t;

  // These are the opcode values of the IR[31:26] field.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSrc codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // This is the raw Moore control word for one state, before the top applies
  // reset and handshake gating. The branch_ne field stays 0 when the bne
  // extension is not built.
  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       instr_done;
  } ctrl_word_t;

  // This returns 1 for every opcode that DECODE dispatches to an execute state.
  function automatic logic opcode_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
`ifdef MULTICYCLE_BNE_EN
    legal = legal || (op == OP_BNE);
`endif
    return legal;
  endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_output_decoder.sv
`default_nettype none
// ============================================================================
// Module : mc_output_decoder
// Brief  : Purely combinational map from FSM state to the raw Moore control
//          word. Fields that do not matter in a state are driven to 0, as are
//          all fields for unused encodings.
// Ports  : state (in, state_t)      current FSM state
//          ctrl  (out, ctrl_word_t) raw control word, not gated
// Config : MULTICYCLE_BNE_EN adds the BNEEX decode.
// Rev    : 1.0  initial release
// ============================================================================
module mc_output_decoder
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // This state computes PC+4. IRWrite and PCWrite are qualified by
        // mem_ready in the top.
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // The ALU precomputes the branch target PC + (SignImm << 2) in case
        // the instruction is a branch.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // The write strobe stays high for every wait cycle. Completion is
        // qualified by mem_ready in the top.
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_BNE_EN
      S_BNEEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch_ne  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule : mc_output_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : multicycle_controller
// Brief  : Multi-cycle control FSM for a shared-memory MIPS datapath. It
//          decodes the opcode in DECODE and then steps through the states of
//          each instruction. It emits one control word per cycle and stalls on
//          the memory ready handshake.
// Ports  : clk, reset (async, active-high)   clock and reset
//          Opcode[OPCODE_W], mem_ready       inputs
//          MemWrite IRWrite RegWrite RegDst MemtoReg IorD ALUSrcA
//          ALUSrcB[2] ALUOp[2] PCSrc[2] PCWrite Branch   control word
//          illegal, instr_done               status pulses
//          state[STATE_W]                    current state, for debug
//          BranchNe                          only with MULTICYCLE_BNE_EN
// Config : MULTICYCLE_BNE_EN enables opcode 000101 (bne) and the BranchNe
//          port.
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                IorD,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                PCWrite,
  output logic                Branch,
`ifdef MULTICYCLE_BNE_EN
  output logic                BranchNe,
`endif
  output logic                illegal,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t ctrl;
  logic       out_en;
  logic       mem_wait;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:       state_d = S_RTYPEEX;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BEQEX;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JEX;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:         state_d = S_BNEEX;
`endif
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // The IR still holds the opcode. Any other value here can only come
        // from a corrupted IR, so the FSM goes back to FETCH.
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX:
                 state_d = S_FETCH;
`ifdef MULTICYCLE_BNE_EN
      S_BNEEX:   state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Output decode and gating
  // ---------------------------------------------------------------------
  mc_output_decoder u_dec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // out_en forces every strobe to 0 while reset is high. This prevents a
  // partial write, even on the cycle that reset is asserted.
  assign out_en   = ~reset;

  // mem_wait marks the cycles in which the memory has not yet completed the
  // access. While it is high the FETCH loads and the MEMWR completion pulse
  // are held back.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR)) && !mem_ready;

  assign MemWrite   = ctrl.mem_write  & out_en;
  assign IRWrite    = ctrl.ir_write   & ~mem_wait & out_en;
  assign PCWrite    = ctrl.pc_write   & ~mem_wait & out_en;
  assign instr_done = ctrl.instr_done & ~mem_wait & out_en;
  assign RegWrite   = ctrl.reg_write  & out_en;
  assign Branch     = ctrl.branch     & out_en;
`ifdef MULTICYCLE_BNE_EN
  assign BranchNe   = ctrl.branch_ne  & out_en;
`endif
  assign illegal    = (state_q == S_DECODE) & ~opcode_legal(Opcode) & out_en;

  // The mux selects are plain Moore outputs. The state is FETCH during reset,
  // so they already show the FETCH values.
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign IorD     = ctrl.iord;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;

  assign state = STATE_W'(state_q);

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Self-checking bench for multicycle_controller. A reference model at
//          the instruction level builds the phase list of each instruction. It
//          derives the expected control outputs for every cycle, including
//          memory stalls.
// Config : MULTICYCLE_BNE_EN must match the RTL build.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [5:0] Opcode;
  logic       MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, IorD, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCWrite, Branch, illegal, instr_done;
  logic [3:0] state;
  logic       bne_obs;
`ifdef MULTICYCLE_BNE_EN
  logic       BranchNe;
  assign bne_obs = BranchNe;
`else
  assign bne_obs = 1'b0;
`endif

  multicycle_controller #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Opcode     (Opcode),
    .mem_ready  (mem_ready),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .IorD       (IorD),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
`ifdef MULTICYCLE_BNE_EN
    .BranchNe   (BranchNe),
`endif
    .illegal    (illegal),
    .instr_done (instr_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, IorD, ALUSrcA,
                    ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, bne_obs, illegal, instr_done};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // These are the instruction phases of the reference model.
  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5,
                 PH_RE = 6, PH_RWB = 7, PH_BQ = 8, PH_AE = 9, PH_AWB = 10,
                 PH_J = 11, PH_BN = 12;

  function automatic bit is_legal(input logic [5:0] op);
    bit l;
    l = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
        (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
`ifdef MULTICYCLE_BNE_EN
    l = l || (op == 6'b000101);
`endif
    return l;
  endfunction

  // These are the expected control outputs for one cycle of a phase, given
  // mem_ready and the opcode.
  function automatic logic [17:0] exp_out(input int ph, input logic mr, input logic [5:0] op);
    logic mw, irw, rw, rdst, m2r, iord, sa, pcw, br, bne, ill, done;
    logic [1:0] sb, aop, pcs;
    {mw, irw, rw, rdst, m2r, iord, sa, pcw, br, bne, ill, done} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (ph)
      PH_F:   begin sb = 2'b01; irw = mr; pcw = mr; end
      PH_D:   begin sb = 2'b11; ill = !is_legal(op); end
      PH_MA:  begin sa = 1; sb = 2'b10; end
      PH_MR:  begin iord = 1; end
      PH_MWB: begin rw = 1; m2r = 1; done = 1; end
      PH_MW:  begin iord = 1; mw = 1; done = mr; end
      PH_RE:  begin sa = 1; aop = 2'b10; end
      PH_RWB: begin rw = 1; rdst = 1; done = 1; end
      PH_BQ:  begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; done = 1; end
      PH_BN:  begin sa = 1; aop = 2'b01; pcs = 2'b01; bne = 1; done = 1; end
      PH_AE:  begin sa = 1; sb = 2'b10; end
      PH_AWB: begin rw = 1; done = 1; end
      PH_J:   begin pcs = 2'b10; pcw = 1; done = 1; end
      default: ;
    endcase
    return {mw, irw, rw, rdst, m2r, iord, sa, sb, aop, pcs, pcw, br, bne, ill, done};
  endfunction

  function automatic logic [3:0] ph_state(input int ph);
    case (ph)
      PH_F:   return S_FETCH;
      PH_D:   return S_DECODE;
      PH_MA:  return S_MEMADR;
      PH_MR:  return S_MEMRD;
      PH_MWB: return S_MEMWB;
      PH_MW:  return S_MEMWR;
      PH_RE:  return S_RTYPEEX;
      PH_RWB: return S_RTYPEWB;
      PH_BQ:  return S_BEQEX;
      PH_AE:  return S_ADDIEX;
      PH_AWB: return S_ADDIWB;
      PH_J:   return S_JEX;
`ifdef MULTICYCLE_BNE_EN
      PH_BN:  return S_BNEEX;
`endif
      default: return 4'hF;
    endcase
  endfunction

  // This task runs one instruction from FETCH. The mode selects the
  // mem_ready pattern: 0 = random, 1 = always ready, 2 = three wait cycles
  // in the store phase.
  task automatic run_instr(input logic [5:0] op, input int mode,
                           output int n_cyc, output int n_mw, output int n_done);
    int   ph_q[$];
    int   idx, ph, stall_left, n_ill;
    logic mr;
    ph_q = {PH_F, PH_D};
    if (is_legal(op)) begin
      case (op)
        6'b100011: ph_q = {ph_q, PH_MA, PH_MR, PH_MWB};
        6'b101011: ph_q = {ph_q, PH_MA, PH_MW};
        6'b000000: ph_q = {ph_q, PH_RE, PH_RWB};
        6'b001000: ph_q = {ph_q, PH_AE, PH_AWB};
        6'b000100: ph_q.push_back(PH_BQ);
        6'b000010: ph_q.push_back(PH_J);
        6'b000101: ph_q.push_back(PH_BN);
        default: ;
      endcase
    end
    idx = 0; n_cyc = 0; n_mw = 0; n_done = 0; n_ill = 0; stall_left = 3;
    while (idx < ph_q.size() && n_cyc < 60) begin
      @(negedge clk);
      ph = ph_q[idx];
      case (mode)
        1:       mr = 1'b1;
        2:       if (ph == PH_MW && stall_left > 0) begin mr = 1'b0; stall_left--; end
                 else mr = 1'b1;
        default: mr = ($urandom_range(0, 9) < 7);
      endcase
      mem_ready = mr;
      Opcode    = (ph == PH_F) ? 6'($urandom) : op;
      #2;
      check_eq("ctrl", 32'(dut_vec), 32'(exp_out(ph, mr, op)));
      check_eq("state", 32'(state), 32'(ph_state(ph)));
      n_mw   += int'(MemWrite);
      n_done += int'(instr_done);
      n_ill  += int'(illegal);
      if (!((ph == PH_F || ph == PH_MR || ph == PH_MW) && !mr)) idx++;
      n_cyc++;
    end
    check_eq("phase_budget", idx, ph_q.size());
    check_eq("done_count", n_done, is_legal(op) ? 1 : 0);
    check_eq("illegal_count", n_ill, is_legal(op) ? 0 : 1);
  endtask

  initial begin
    int cyc, mwc, dn;
    logic [5:0] picks [0:8];
    picks = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100,
              6'b000010, 6'b000101, 6'b111111, 6'b000000};

    // Reset state. The strobes stay low even though mem_ready is high.
    reset = 1'b1; mem_ready = 1'b1; Opcode = 6'b100011;
    repeat (2) begin
      @(negedge clk); #2;
      check_eq("reset_ctrl", 32'(dut_vec), 32'(exp_out(PH_F, 1'b0, 6'd0)));
      check_eq("reset_state", 32'(state), 32'(S_FETCH));
    end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0;

    // Drive lw into MEMRD, then assert reset mid-instruction.
    @(negedge clk); mem_ready = 1'b1; Opcode = 6'b100011;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0; #2;
    check_eq("pre_reset_state", 32'(state), 32'(S_MEMRD));
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
    check_eq("async_reset_state", 32'(state), 32'(S_FETCH));
    check_eq("async_reset_ctrl", 32'(dut_vec), 32'(exp_out(PH_F, 1'b0, 6'd0)));
    @(negedge clk); #2;
    check_eq("held_reset_ctrl", 32'(dut_vec), 32'(exp_out(PH_F, 1'b0, 6'd0)));
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #2;
    check_eq("first_fetch_ctrl", 32'(dut_vec), 32'(exp_out(PH_F, 1'b1, 6'd0)));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0;

    // Latency of each instruction with no memory stalls.
    run_instr(6'b100011, 1, cyc, mwc, dn); check_eq("lat_lw", cyc, 5);
    run_instr(6'b101011, 1, cyc, mwc, dn); check_eq("lat_sw", cyc, 4);
    run_instr(6'b000000, 1, cyc, mwc, dn); check_eq("lat_r", cyc, 4);
    run_instr(6'b001000, 1, cyc, mwc, dn); check_eq("lat_addi", cyc, 4);
    run_instr(6'b000100, 1, cyc, mwc, dn); check_eq("lat_beq", cyc, 3);
    run_instr(6'b000010, 1, cyc, mwc, dn); check_eq("lat_j", cyc, 3);
    run_instr(6'b111111, 1, cyc, mwc, dn); check_eq("lat_illegal", cyc, 2);
    run_instr(6'b000101, 1, cyc, mwc, dn);
    check_eq("lat_bne", cyc, is_legal(6'b000101) ? 3 : 2);

    // A store that waits three cycles for the memory.
    run_instr(6'b101011, 2, cyc, mwc, dn);
    check_eq("sw_stall_memwrite", mwc, 4);
    check_eq("sw_stall_cycles", cyc, 7);

    // Random instruction mix with random memory stalls.
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int k;
      k  = $urandom_range(0, 9);
      op = (k == 9) ? 6'($urandom) : picks[k];
      run_instr(op, 0, cyc, mwc, dn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multicycle_controller
`default_nettype wire
